// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage core pipeline control blocks.
//   - register-index width and the hard-wired zero register index
//   - hazard sequencer state encoding (ST_RUN / ST_STALL / ST_FLUSH) and the
//     enum built on it, so the debug state output decodes the same everywhere
//   - width of the stall/flush down-counter and a helper that forms its load
//     value from a cycle-count parameter
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        S_RUN   = ST_RUN,
        S_STALL = ST_STALL,
        S_FLUSH = ST_FLUSH
    } haz_state_e;

    localparam int HAZ_CNT_W = 3;

    // The cycle in which the hazard is detected is the first of the N cycles,
    // so the counter is loaded with N-1 remaining cycles.
    function automatic logic [HAZ_CNT_W-1:0] haz_cnt_load(input int n);
        return HAZ_CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/haz_perf_cnt.sv
// -----------------------------------------------------------------------------
// haz_perf_cnt
// Saturating event counter used for hazard performance statistics.
// Ports:
//   clk    in   1      core clock, rising edge
//   clr    in   1      synchronous clear (dominates inc)
//   inc    in   1      count one event this cycle
//   count  out  CNT_W  current count, holds at all-ones once reached
// -----------------------------------------------------------------------------
module haz_perf_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Pipeline hazard sequencer for the 5-stage core, placed beside the EX-stage
// forwarding logic. Handles what forwarding cannot:
//   - load-use: holds PC and IF/ID and bubbles ID/EX for LOAD_STALL cycles
//   - taken branch: flushes IF/ID and ID/EX for FLUSH_CYCLES cycles
// Detection is combinational, so the first stall/flush cycle is the detection
// cycle itself; a 3-bit down-counter covers the remaining cycles.
//
// There is no valid/ready handshake here: every input is a level sampled each
// cycle, every control output is valid in the same cycle.
//
// Parameters:
//   LOAD_STALL    bubbles per load-use hazard (1..7)
//   FLUSH_CYCLES  flush cycles per taken branch (1..7)
//   CNT_W         perf counter width
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   id_rs, id_rt  source registers of the instruction in ID
//   id_uses_rt    ID instruction reads rt
//   ex_mem_read   instruction in EX is a load
//   ex_rt         load destination in EX
//   branch_taken  branch resolved taken in EX
//   pc_write      PC enable
//   ifid_write    IF/ID enable
//   ifid_flush    IF/ID cleared to nop
//   idex_bubble   ID/EX control zeroed
//   busy          sequencer not in RUN
//   stall_cnt_o   cycles with ifid_write low (perf build only)
//   flush_cnt_o   accepted taken branches (perf build only)
//   state_dbg     current sequencer state (pipe_pkg ST_* encoding)
// Configuration:
//   HAZ_PERF_CNT_EN  defined: build the two saturating perf counters;
//                    undefined: perf ports tied to 0, no counter flops.
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [1:0]       state_dbg
);

    // Elaboration-time range check of the cycle-count parameters.
    if ((LOAD_STALL < 1) || (LOAD_STALL > 7)) begin : g_bad_load_stall
        $error("hazard_stall_ctrl: LOAD_STALL=%0d out of range 1..7", LOAD_STALL);
    end
    if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 7)) begin : g_bad_flush_cycles
        $error("hazard_stall_ctrl: FLUSH_CYCLES=%0d out of range 1..7", FLUSH_CYCLES);
    end

    localparam logic [HAZ_CNT_W-1:0] STALL_LOAD = haz_cnt_load(LOAD_STALL);
    localparam logic [HAZ_CNT_W-1:0] FLUSH_LOAD = haz_cnt_load(FLUSH_CYCLES);
    localparam bit STALL_MULTI = (LOAD_STALL > 1);
    localparam bit FLUSH_MULTI = (FLUSH_CYCLES > 1);

    haz_state_e           state, state_nxt;
    logic [HAZ_CNT_W-1:0] cnt, cnt_nxt;
    logic                 luh;

    // $0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign luh = ex_mem_read && (ex_rt != REG_ZERO) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        busy        = 1'b0;

        // Outputs read as RUN for the whole time reset is held.
        if (!rst) begin
            unique case (state)
                S_RUN: begin
                    // A taken branch kills the dependent instruction, so it
                    // takes priority over the load-use stall.
                    if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        if (FLUSH_MULTI) begin
                            state_nxt = S_FLUSH;
                            cnt_nxt   = FLUSH_LOAD;
                        end
                    end else if (luh) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        if (STALL_MULTI) begin
                            state_nxt = S_STALL;
                            cnt_nxt   = STALL_LOAD;
                        end
                    end
                end

                S_STALL: begin
                    busy = 1'b1;
                    if (branch_taken) begin
                        // Abort the stall: the stalled instruction is flushed,
                        // and this cycle is the first flush cycle.
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        if (FLUSH_MULTI) begin
                            state_nxt = S_FLUSH;
                            cnt_nxt   = FLUSH_LOAD;
                        end else begin
                            state_nxt = S_RUN;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        cnt_nxt     = cnt - 1'b1;
                        if (cnt == HAZ_CNT_W'(1)) begin
                            state_nxt = S_RUN;
                        end
                    end
                end

                S_FLUSH: begin
                    // branch_taken is ignored here; the count stands.
                    busy        = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    cnt_nxt     = cnt - 1'b1;
                    if (cnt == HAZ_CNT_W'(1)) begin
                        state_nxt = S_RUN;
                    end
                end

                default: begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign state_dbg = state;

`ifdef HAZ_PERF_CNT_EN
    logic flush_accept;

    // A branch is accepted in RUN or STALL; branches seen in FLUSH are dropped.
    assign flush_accept = branch_taken && !rst && (state != S_FLUSH);

    haz_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (!ifid_write),
        .count (stall_cnt_o)
    );

    haz_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (flush_accept),
        .count (flush_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Three instances with different cycle counts, each with its own inputs:
//   dut 0: LOAD_STALL=1 FLUSH_CYCLES=1
//   dut 1: LOAD_STALL=3 FLUSH_CYCLES=2
//   dut 2: LOAD_STALL=2 FLUSH_CYCLES=1  (perf counter checks)
// Expected item: {kind, sel[1:0], chk_state, data[31:0]}
//   kind 0: data[6:0] = {state, pc_write, ifid_write, ifid_flush, idex_bubble, busy}
//   kind 1: data = {stall_cnt_o, flush_cnt_o}
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 16;
    localparam int W     = 36;

`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]       id_rs [3];
    logic [4:0]       id_rt [3];
    logic [4:0]       ex_rt [3];
    logic             id_uses_rt [3];
    logic             ex_mem_read [3];
    logic             branch_taken [3];
    logic             pc_write [3];
    logic             ifid_write [3];
    logic             ifid_flush [3];
    logic             idex_bubble [3];
    logic             busy [3];
    logic [CNT_W-1:0] stall_cnt [3];
    logic [CNT_W-1:0] flush_cnt [3];
    logic [1:0]       state_dbg [3];

    hazard_stall_ctrl #(.LOAD_STALL(1), .FLUSH_CYCLES(1), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst(rst), .id_rs(id_rs[0]), .id_rt(id_rt[0]),
        .id_uses_rt(id_uses_rt[0]), .ex_mem_read(ex_mem_read[0]), .ex_rt(ex_rt[0]),
        .branch_taken(branch_taken[0]), .pc_write(pc_write[0]), .ifid_write(ifid_write[0]),
        .ifid_flush(ifid_flush[0]), .idex_bubble(idex_bubble[0]), .busy(busy[0]),
        .stall_cnt_o(stall_cnt[0]), .flush_cnt_o(flush_cnt[0]), .state_dbg(state_dbg[0])
    );

    hazard_stall_ctrl #(.LOAD_STALL(3), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs[1]), .id_rt(id_rt[1]),
        .id_uses_rt(id_uses_rt[1]), .ex_mem_read(ex_mem_read[1]), .ex_rt(ex_rt[1]),
        .branch_taken(branch_taken[1]), .pc_write(pc_write[1]), .ifid_write(ifid_write[1]),
        .ifid_flush(ifid_flush[1]), .idex_bubble(idex_bubble[1]), .busy(busy[1]),
        .stall_cnt_o(stall_cnt[1]), .flush_cnt_o(flush_cnt[1]), .state_dbg(state_dbg[1])
    );

    hazard_stall_ctrl #(.LOAD_STALL(2), .FLUSH_CYCLES(1), .CNT_W(CNT_W)) dut2 (
        .clk(clk), .rst(rst), .id_rs(id_rs[2]), .id_rt(id_rt[2]),
        .id_uses_rt(id_uses_rt[2]), .ex_mem_read(ex_mem_read[2]), .ex_rt(ex_rt[2]),
        .branch_taken(branch_taken[2]), .pc_write(pc_write[2]), .ifid_write(ifid_write[2]),
        .ifid_flush(ifid_flush[2]), .idex_bubble(idex_bubble[2]), .busy(busy[2]),
        .stall_cnt_o(stall_cnt[2]), .flush_cnt_o(flush_cnt[2]), .state_dbg(state_dbg[2])
    );

    // Expected {state, pc_write, ifid_write, ifid_flush, idex_bubble, busy}
    localparam logic [6:0] E_RUN      = 7'b00_11000;
    localparam logic [6:0] E_LUH      = 7'b00_00010;
    localparam logic [6:0] E_STALL    = 7'b01_00011;
    localparam logic [6:0] E_BR       = 7'b00_11110;
    localparam logic [6:0] E_FLUSH    = 7'b10_11111;
    localparam logic [6:0] E_STALL_BR = 7'b01_11111;
    localparam logic [6:0] E_STALL_RS = 7'b01_11000;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- driver tasks ----------------
    task automatic step(input int sel, input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses_rt, input logic mem_read, input logic [4:0] ert,
                        input logic br, input logic rst_v, input logic chk_st,
                        input logic [6:0] exp_v);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            id_rs[i] = '0; id_rt[i] = '0; ex_rt[i] = '0;
            id_uses_rt[i] = 1'b0; ex_mem_read[i] = 1'b0; branch_taken[i] = 1'b0;
        end
        id_rs[sel]        = rs;
        id_rt[sel]        = rt;
        id_uses_rt[sel]   = uses_rt;
        ex_mem_read[sel]  = mem_read;
        ex_rt[sel]        = ert;
        branch_taken[sel] = br;
        rst               = rst_v;
        exp_q.push_back({1'b0, 2'(sel), chk_st, 25'd0, exp_v});
    endtask

    task automatic idle(input int sel, input logic [6:0] exp_v);
        step(sel, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, exp_v);
    endtask

    // Checks perf counters in the cycle of the most recent step.
    task automatic perf_chk(input int sel, input int st, input int fl);
        logic [CNT_W-1:0] es, ef;
        es = PERF ? CNT_W'(st) : '0;
        ef = PERF ? CNT_W'(fl) : '0;
        exp_q.push_back({1'b1, 2'(sel), 1'b0, es, ef});
    endtask

    // ---------------- monitor ----------------
    logic [W-1:0] item;
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            int s;
            logic [6:0]  act7;
            logic [31:0] act32;
            item = exp_q.pop_front();
            s = int'(item[34:33]);
            n_tests++;
            if (item[35] == 1'b0) begin
                act7 = {state_dbg[s], pc_write[s], ifid_write[s], ifid_flush[s],
                        idex_bubble[s], busy[s]};
                if (item[32] ? (act7 !== item[6:0]) : (act7[4:0] !== item[4:0])) begin
                    n_fail++;
                    $display("FAIL ctrl dut%0d check %0d: got st/pw/iw/fl/bb/busy=%b want %b (state checked=%0d)",
                             s, n_tests, act7, item[6:0], item[32]);
                end
            end else begin
                act32 = {stall_cnt[s], flush_cnt[s]};
                if (act32 !== item[31:0]) begin
                    n_fail++;
                    $display("FAIL perf dut%0d check %0d: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                             s, n_tests, act32[31:16], act32[15:0], item[31:16], item[15:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 3; i++) begin
            id_rs[i] = '0; id_rt[i] = '0; ex_rt[i] = '0;
            id_uses_rt[i] = 1'b0; ex_mem_read[i] = 1'b0; branch_taken[i] = 1'b0;
        end

        // Reset: outputs read RUN values while rst=1 even with events present.
        step(0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, E_RUN);
        step(1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, E_RUN);
        step(2, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_RUN);
        idle(0, E_RUN);
        idle(1, E_RUN);
        idle(2, E_RUN);
        perf_chk(2, 0, 0);

        // Load-use on rs, LOAD_STALL=1: one bubble then RUN.
        step(0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, E_LUH);
        idle(0, E_RUN);
        // Not a load: no hazard.
        step(0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, E_RUN);
        // Branch with FLUSH_CYCLES=1: one flush cycle, stays in RUN.
        step(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, E_BR);
        idle(0, E_RUN);

        // Load-use on rt, LOAD_STALL=3: three stall cycles, busy on 2 and 3.
        step(1, 5'd3, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, E_LUH);
        idle(1, E_STALL);
        idle(1, E_STALL);
        idle(1, E_RUN);
        // Same registers but rt not read: no stall.
        step(1, 5'd3, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, E_RUN);

        // Load to $0 never stalls.
        step(0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, E_RUN);
        step(1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, E_RUN);

        // Branch and load-use together: branch wins, 2 flush cycles.
        step(1, 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, E_BR);
        idle(1, E_FLUSH);
        idle(1, E_RUN);
        // Branch in stall cycle 2: flush from that cycle for 2 cycles total.
        step(1, 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, E_LUH);
        step(1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, E_STALL_BR);
        idle(1, E_FLUSH);
        idle(1, E_RUN);
        // Branch during FLUSH is ignored.
        step(1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, E_BR);
        step(1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, E_FLUSH);
        idle(1, E_RUN);
        // Reset mid-stall discards the remaining count.
        step(1, 5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, E_LUH);
        step(1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, E_STALL_RS);
        idle(1, E_RUN);

        // Perf: 3 hazards at LOAD_STALL=2 and 2 branches -> 6 and 2.
        for (int k = 0; k < 3; k++) begin
            step(2, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, E_LUH);
            idle(2, E_STALL);
            idle(2, E_RUN);
        end
        step(2, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, E_BR);
        step(2, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, E_BR);
        idle(2, E_RUN);
        perf_chk(2, 6, 2);
        // Reset mid-stall: counters still hold during rst, read 0 afterwards.
        step(2, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, E_LUH);
        step(2, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, E_STALL_RS);
        perf_chk(2, 7, 2);
        idle(2, E_RUN);
        perf_chk(2, 0, 0);

        // ---------------- final report ----------------
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d items left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
